// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_PACK = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_t;

  function automatic int PACKER_CNT_W(input int p);
    return $clog2(p + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-beat valid/ready bundle.
// FIFO_RD_PACKER_PARITY_EN adds out_parity.
interface fifo_rd_packer_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK = DEF_PACK
);
  localparam int OUT_WIDTH = DATA_WIDTH * PACK;
  localparam int CW = PACKER_CNT_W(PACK);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic                  flush;
  logic [OUT_WIDTH-1:0]  out_data;
  logic [CW-1:0]         out_count;
  logic                  out_valid;
  logic                  out_ready;
`ifdef FIFO_RD_PACKER_PARITY_EN
  logic                  out_parity;

  modport master (
    input  fifo_empty, fifo_data, flush, out_ready,
    output fifo_rd_en, out_data, out_count, out_valid,
    output out_parity
  );
  modport slave (
    output fifo_empty, fifo_data, flush, out_ready,
    input  fifo_rd_en, out_data, out_count, out_valid,
    input  out_parity
  );
`else
  modport master (
    input  fifo_empty, fifo_data, flush, out_ready,
    output fifo_rd_en, out_data, out_count, out_valid
  );
  modport slave (
    output fifo_empty, fifo_data, flush, out_ready,
    input  fifo_rd_en, out_data, out_count, out_valid
  );
`endif

endinterface

// File: rtl/fifo_rd_packer.sv
// Pops narrow FIFO words and packs PACK of them per output beat.
// FIFO_RD_PACKER_PARITY_EN adds a registered parity of the beat.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK = DEF_PACK
) (
  input logic rd_clk,
  input logic rd_reset,
  fifo_rd_packer_if.master bus
);

  localparam int OUT_WIDTH = DATA_WIDTH * PACK;
  localparam int CW = PACKER_CNT_W(PACK);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);
  localparam logic [CW:0] PACK_W = (CW + 1)'(PACK);

  packer_state_t        state_q, state_d;
  logic [CW-1:0]        fill_cnt_q, fill_cnt_d;
  logic                 inflight_q, inflight_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [OUT_WIDTH-1:0] lanes_q, lanes_d;
  logic [CW:0]          occ;
  logic                 pop;
  logic                 flush_go;

  assign occ = {1'b0, fill_cnt_q} + {{CW{1'b0}}, inflight_q};

  assign pop = rd_reset
             & (state_q == FILL)
             & !bus.fifo_empty
             & (occ < PACK_W)
             & !flush_pend_q;

  assign bus.fifo_rd_en = pop;
  assign bus.out_data   = lanes_q;
  assign bus.out_count  = fill_cnt_q;
  assign bus.out_valid  = (state_q == HOLD);

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    inflight_d   = pop;
    flush_pend_d = flush_pend_q;
    lanes_d      = lanes_q;
    flush_go     = 1'b0;
    unique case (state_q)
      FILL: begin
        for (int i = 0; i < PACK; i++) begin
          if (inflight_q && fill_cnt_q == CW'(i)) begin
            lanes_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
          end
        end
        if (inflight_q) begin
          fill_cnt_d = fill_cnt_q + CW'(1);
        end
        // An empty packer with nothing in flight has no tail to emit.
        flush_go = flush_pend_q
                 | (bus.flush & ((fill_cnt_q != '0) | inflight_q));
        if (fill_cnt_d == PACK_C || (flush_go && !pop)) begin
          state_d      = HOLD;
          flush_pend_d = 1'b0;
        end else begin
          flush_pend_d = flush_go;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d      = FILL;
          lanes_d      = '0;
          fill_cnt_d   = '0;
          flush_pend_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_reset) begin
    if (!rd_reset) begin
      state_q      <= FILL;
      fill_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      lanes_q      <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      lanes_q      <= lanes_d;
    end
  end

`ifdef FIFO_RD_PACKER_PARITY_EN
  // Unfilled lanes are zero, so the XOR of all lanes covers only valid ones.
  logic parity_q;

  always_ff @(posedge rd_clk or negedge rd_reset) begin
    if (!rd_reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^lanes_d;
    end
  end

  assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: FIFO model, word-level packing model.
module tb_fifo_rd_packer;

  localparam int DW = 4;
  localparam int PK = 4;
  localparam int OW = DW * PK;

  typedef struct {
    logic [OW-1:0] d;
    int            c;
  } beat_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   pops;
  int   pop_cyc;
  int   valid_cyc;
  int   flush_cyc;
  bit   force_empty;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] pend[$];
  beat_t         expq[$];

  fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) bus ();

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .rd_clk  (clk),
    .rd_reset(rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  // Expected beat: the words popped since the last beat, oldest in lane 0.
  function automatic beat_t mk_beat();
    beat_t b;
    b.d = '0;
    foreach (pend[i]) b.d[i*DW +: DW] = pend[i];
    b.c = pend.size();
    return b;
  endfunction

  task automatic step();
    logic          dp;
    logic          fl;
    logic [DW-1:0] w;
    bus.fifo_empty = force_empty || (fq.size() == 0);
    @(negedge clk);
    dp = bus.fifo_rd_en;
    fl = bus.flush;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    if (dp && fq.size() > 0) begin
      w = fq.pop_front();
      bus.fifo_data = w;
      pops++;
      if (pop_cyc < 0) pop_cyc = cyc;
      pend.push_back(w);
      if (pend.size() == PK) begin
        expq.push_back(mk_beat());
        pend.delete();
      end
    end
    if (fl) begin
      flush_cyc = cyc;
      if (pend.size() > 0) begin
        expq.push_back(mk_beat());
        pend.delete();
      end
    end
    bus.fifo_empty = force_empty || (fq.size() == 0);
  endtask

  task automatic pulse_flush();
    bus.flush   = 1'b1;
    force_empty = 1'b1;
    step();
    force_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fq.delete();
    pend.delete();
    expq.delete();
    bus.fifo_empty = 1'b0;
    #5;
    chk("rst_data", 32'(bus.out_data), 32'h0);
    chk("rst_count", 32'(bus.out_count), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_rden", 32'(bus.fifo_rd_en), 32'h0);
    #15;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.fifo_empty = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
  endtask

  logic [OW-1:0] held_d;
  bit            held;

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      held = 0;
    end else if (bus.out_valid) begin
      if (valid_cyc < 0) valid_cyc = cyc;
      chk("rden_in_hold", 32'(bus.fifo_rd_en), 32'h0);
      if (held) chk("hold_stable", 32'(bus.out_data), 32'(held_d));
      if (bus.out_ready) begin
        held = 0;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat got=%0h exp=none", bus.out_data);
        end else begin
          e = expq.pop_front();
          chk("beat_data", 32'(bus.out_data), 32'(e.d));
          chk("beat_count", 32'(bus.out_count), 32'(e.c));
`ifdef FIFO_RD_PACKER_PARITY_EN
          chk("beat_parity", 32'(bus.out_parity), 32'(^e.d));
`endif
        end
      end else begin
        held   = 1;
        held_d = bus.out_data;
      end
    end
  end

  initial begin
    int p0;
    total = 0;
    bad = 0;
    pops = 0;
    pop_cyc = -1;
    valid_cyc = -1;
    flush_cyc = -1;
    force_empty = 0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    bus.fifo_data = '0;
    bus.fifo_empty = 1'b1;
    held = 0;
    do_reset();

    // Full beat with latency check.
    bus.out_ready = 1'b1;
    p0 = pops;
    pop_cyc = -1;
    valid_cyc = -1;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    repeat (10) step();
    chk("full_pops", 32'(pops - p0), 32'd4);
    chk("full_latency", 32'(valid_cyc - pop_cyc), 32'(PK));

    // Backpressure.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    repeat (10) step();
    chk("bp_valid", 32'(bus.out_valid), 32'h1);
    bus.out_ready = 1'b1;
    repeat (12) step();

    // Flush after two captures, nothing in flight.
    push(4'hA);
    push(4'hB);
    repeat (4) step();
    valid_cyc = -1;
    pulse_flush();
    repeat (3) step();
    chk("flush_latency", 32'(valid_cyc - flush_cyc), 32'h0);

    // Flush on the edge where B is still in flight.
    push(4'hA);
    push(4'hB);
    step();
    step();
    pulse_flush();
    repeat (4) step();

    // Empty stall mid-fill.
    for (int i = 1; i <= 3; i++) push(DW'(i + 8));
    repeat (4) step();
    force_empty = 1'b1;
    repeat (10) step();
    chk("stall_no_valid", 32'(bus.out_valid), 32'h0);
    force_empty = 1'b0;
    push(4'hC);
    repeat (6) step();

    // Reset mid-beat.
    push(4'h1);
    push(4'h2);
    push(4'h3);
    repeat (3) step();
    do_reset();
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("post_rst_idle", 32'(bus.out_valid), 32'h0);
    for (int i = 5; i <= 8; i++) push(DW'(i));
    repeat (8) step();

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      int n;
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        if (fq.size() < 8) push(DW'($urandom_range(0, 15)));
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      force_empty = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 19) == 0) begin
        pulse_flush();
      end else begin
        step();
      end
    end

    // Drain and flush the tail.
    force_empty = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300 && fq.size() > 0; i++) step();
    repeat (2) step();
    pulse_flush();
    for (int i = 0; i < 30 && expq.size() > 0; i++) step();
    repeat (2) step();
    chk("drain_empty", 32'(expq.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
